// File: rtl/psum_collector.sv
// Partial-sum collector: holds PE opsums between channel-group passes,
// replays them as ipsum on the next pass and emits final ofmap values.
module psum_collector #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = 5,
  parameter bit RELU_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_psum_num,
  input  logic [3:0]        cfg_pass_num,
  output logic              ipsum_enable,
  input  logic              ipsum_ready,
  output logic [DATA_W-1:0] ipsum,
  input  logic              opsum_enable,
  output logic              opsum_ready,
  input  logic [DATA_W-1:0] opsum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    COLLECT,
    FIN
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] psum_num;
  logic [3:0]        pass;
  logic [3:0]        pass_num;
  logic [DATA_W-1:0] mem [DEPTH];

  logic last_pass;
  logic last_idx;
  logic op_hs;
  logic out_hs;
  logic neg;

  assign last_pass = (pass == pass_num);
  assign last_idx  = (idx == psum_num);
  assign op_hs     = opsum_enable & opsum_ready;
  assign out_hs    = out_valid & out_ready;
  assign neg       = RELU_EN & opsum[DATA_W-1];
  assign busy      = (state != IDLE);

  // Pass 0 has no history, so the PE starts from zero.
  assign ipsum = (ipsum_enable && pass != 4'd0) ? mem[idx] : '0;

  always_comb begin
    state_n      = state;
    ipsum_enable = 1'b0;
    opsum_ready  = 1'b0;
    done         = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = FEED;
      end
      FEED: begin
        ipsum_enable = 1'b1;
        if (ipsum_ready) state_n = COLLECT;
      end
      COLLECT: begin
        // Final pass only takes a value when the output slot can hold it.
        opsum_ready = !last_pass || !out_valid || out_ready;
        if (opsum_enable && opsum_ready)
          state_n = (last_pass && last_idx) ? FIN : FEED;
      end
      FIN: begin
        if (!out_valid) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      pass      <= '0;
      psum_num  <= '0;
      pass_num  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        psum_num <= cfg_psum_num;
        pass_num <= cfg_pass_num;
        idx      <= '0;
        pass     <= '0;
      end
      if (op_hs) begin
        if (last_idx) begin
          idx  <= '0;
          pass <= pass + 4'd1;
        end else begin
          idx <= idx + 1'b1;
        end
      end
      if (op_hs && last_pass) begin
        out_valid <= 1'b1;
        out_data  <= neg ? '0 : opsum;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (op_hs && !last_pass) mem[idx] <= opsum;
  end

endmodule

// File: tb/tb_psum_collector.sv
// Scoreboard bench for psum_collector: PE-side driver plus
// output monitor checking ipsum replay, ReLU output and done.
module tb_psum_collector;

  localparam int DW = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] cfg_psum_num = '0;
  logic [3:0]    cfg_pass_num = '0;
  logic          ipsum_enable;
  logic          ipsum_ready = 1'b0;
  logic [DW-1:0] ipsum;
  logic          opsum_enable = 1'b0;
  logic          opsum_ready;
  logic [DW-1:0] opsum = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;

  psum_collector #(
    .DATA_W (DW),
    .DEPTH  (32),
    .ADDR_W (AW),
    .RELU_EN(1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_psum_num(cfg_psum_num),
    .cfg_pass_num(cfg_pass_num),
    .ipsum_enable(ipsum_enable),
    .ipsum_ready (ipsum_ready),
    .ipsum       (ipsum),
    .opsum_enable(opsum_enable),
    .opsum_ready (opsum_ready),
    .opsum       (opsum),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int hold = 0;
  bit thr_o = 1'b0;

  logic [DW-1:0] exp_ip[$];
  logic [DW-1:0] exp_out[$];
  logic [DW-1:0] ops[$];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] relu(logic [DW-1:0] v);
    return ($signed(v) < 0) ? '0 : v;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (hold > 0) begin
        out_ready = 1'b0;
        hold--;
      end else begin
        out_ready = thr_o ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst) begin
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) chk("out_extra", 1, 0);
        else chk("out_data", out_data, exp_out.pop_front());
      end
      if (out_valid && !out_ready) chk("bp_ordy", opsum_ready, 0);
    end
  end

  task automatic run_job(int n, int pn, bit thr, int abort_idx);
    int b;
    int t;
    exp_ip.delete();
    exp_out.delete();
    done_cnt = 0;
    thr_o = thr;
    for (int p = 0; p <= pn; p++) begin
      for (int i = 0; i <= n; i++) begin
        b = p * (n + 1) + i;
        exp_ip.push_back(p == 0 ? 16'h0 : ops[b-(n+1)]);
        if (p == pn) exp_out.push_back(relu(ops[b]));
      end
    end
    @(negedge clk);
    cfg_psum_num = AW'(n);
    cfg_pass_num = 4'(pn);
    start = 1'b1;
    @(negedge clk);
    cfg_psum_num = AW'($urandom);
    cfg_pass_num = 4'($urandom);
    for (int p = 0; p <= pn; p++) begin
      for (int i = 0; i <= n; i++) begin
        b = p * (n + 1) + i;
        if (abort_idx >= 0 && p == 1 && i == abort_idx) begin
          rst = 1'b0;
          ipsum_ready = 1'b0;
          #1;
          chk("abort_outs", {ipsum_enable, opsum_ready, out_valid,
                             busy, done}, 0);
          @(posedge clk);
          #1;
          chk("abort_done", done, 0);
          repeat (2) @(negedge clk);
          chk("abort_nodone", done_cnt, 0);
          rst = 1'b1;
          exp_ip.delete();
          exp_out.delete();
          thr_o = 1'b0;
          return;
        end
        if (thr && p == pn && i == 0) hold = 5;
        t = 0;
        ipsum_ready = thr ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        while (!(ipsum_enable && ipsum_ready)) begin
          t++;
          if (t > 100) begin
            chk("feed_timeout", t, 0);
            return;
          end
          @(negedge clk);
          ipsum_ready = thr ? 1'($urandom_range(0, 1)) : 1'b1;
          #1;
        end
        chk("ipsum", ipsum, exp_ip.pop_front());
        chk("feed_ordy", opsum_ready, 0);
        @(negedge clk);
        start = 1'b0;
        ipsum_ready = 1'b0;
        opsum = ops[b];
        opsum_enable = thr ? 1'($urandom_range(0, 1)) : 1'b1;
        t = 0;
        #1;
        while (!(opsum_enable && opsum_ready)) begin
          t++;
          if (t > 100) begin
            chk("coll_timeout", t, 0);
            return;
          end
          @(negedge clk);
          if (!opsum_enable) opsum_enable = 1'($urandom_range(0, 1));
          #1;
        end
        @(negedge clk);
        opsum_enable = 1'b0;
      end
    end
    t = 0;
    while (done_cnt == 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("done_cnt", done_cnt, 1);
    chk("out_left", exp_out.size(), 0);
    chk("ip_left", exp_ip.size(), 0);
    chk("busy_end", busy, 0);
    thr_o = 1'b0;
    hold = 0;
  endtask

  initial begin
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      start = 1'($urandom);
      cfg_psum_num = AW'($urandom);
      cfg_pass_num = 4'($urandom);
      ipsum_ready = 1'($urandom);
      opsum_enable = 1'($urandom);
      opsum = DW'($urandom);
      #1;
      chk("rst_outs", {ipsum_enable, opsum_ready, out_valid, busy,
                       done, ipsum, out_data}, 0);
    end
    @(negedge clk);
    start = 1'b0;
    ipsum_ready = 1'b0;
    opsum_enable = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ipen", ipsum_enable, 0);

    ops = '{16'd5, 16'hFFFE, 16'd7, 16'd1};
    run_job(3, 0, 1'b0, -1);

    ops = '{16'd10, 16'd20, 16'd15, 16'd25, 16'hFFFC, 16'd30};
    run_job(1, 2, 1'b0, -1);

    ops.delete();
    repeat (16) ops.push_back(DW'($urandom));
    run_job(7, 1, 1'b1, -1);

    ops.delete();
    repeat (64) ops.push_back(DW'($urandom));
    run_job(31, 1, 1'b0, -1);

    ops.delete();
    repeat (12) ops.push_back(DW'($urandom));
    run_job(3, 2, 1'b0, 1);

    ops.delete();
    repeat (8) ops.push_back(DW'($urandom));
    run_job(3, 1, 1'b1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
